// File: rtl/multi_delay_timer_if.sv
// Signal bundle for multi_delay_timer: enables, release requests, soft clear and channel status.
// MDLY_CNT_RDBK_EN adds the RD_SEL/RD_CNT counter readback pair.
interface multi_delay_timer_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
   logic [NCH-1:0] EN_IN;
   logic [NCH-1:0] DISABLE_IN;
   logic           CLR;
   logic [NCH-1:0] OUT;
   logic [NCH-1:0] BUSY;
`ifdef MDLY_CNT_RDBK_EN
   localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
   logic [SEL_W-1:0] RD_SEL;
   logic [CNT_W-1:0] RD_CNT;

   modport master (output EN_IN, DISABLE_IN, CLR, RD_SEL, input OUT, BUSY, RD_CNT);
   modport slave  (input EN_IN, DISABLE_IN, CLR, RD_SEL, output OUT, BUSY, RD_CNT);
`else
   modport master (output EN_IN, DISABLE_IN, CLR, input OUT, BUSY);
   modport slave  (input EN_IN, DISABLE_IN, CLR, output OUT, BUSY);
`endif
endinterface

// File: rtl/multi_delay_timer.sv
// NCH-channel on/off delay timer with synchronised enable/release inputs and soft clear.
// Optional counter readback (RD_SEL/RD_CNT) when MDLY_CNT_RDBK_EN is defined.
module mdt_chan #(
  parameter int          CNT_W   = 16,
  parameter int unsigned ON_DLY  = 16'h1000,
  parameter int unsigned OFF_DLY = 16'h1000
) (
  input  logic SYSCLK,
  input  logic RESET_N,
  input  logic clr,
  input  logic en_rise,
  input  logic en_fall,
  input  logic dis_fall,
  output logic out,
  output logic busy
`ifdef MDLY_CNT_RDBK_EN
  ,output logic [CNT_W-1:0] cnt_o
`endif
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_ACT  = 2'd2;
   localparam logic [1:0] S_REL  = 2'd3;
   localparam logic [CNT_W-1:0] ON_C  = CNT_W'(ON_DLY);
   localparam logic [CNT_W-1:0] OFF_C = CNT_W'(OFF_DLY);

   logic [1:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   // EN fall and CLR override everything; rise/fall on DISABLE only matter where they apply.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (clr || en_fall) begin
         state_nx = S_IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            S_IDLE: if (en_rise) begin
               state_nx = S_ARM;
               cnt_nx   = ON_C;
            end
            S_ARM: if (dis_fall) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
            else state_nx = S_ACT;
            S_ACT: if (dis_fall) begin
               state_nx = S_REL;
               cnt_nx   = OFF_C;
            end
            S_REL: if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
            else state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
         cnt   <= '0;
         out   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         out   <= (state_nx == S_ACT) || (state_nx == S_REL);
         busy  <= (state_nx == S_ARM) || (state_nx == S_REL);
      end
   end

`ifdef MDLY_CNT_RDBK_EN
   assign cnt_o = cnt;
`endif
endmodule

module multi_delay_timer #(
  parameter int          NCH     = 4,
  parameter int          CNT_W   = 16,
  parameter int unsigned ON_DLY  = 16'h1000,
  parameter int unsigned OFF_DLY = 16'h1000
) (
  input logic               SYSCLK,
  input logic               RESET_N,
  multi_delay_timer_if.slave bus
);
   if (NCH < 1 || NCH > 16) begin : g_bad_nch
      $error("multi_delay_timer: NCH must be 1..16");
   end
   if (64'(ON_DLY) >= (64'd1 << CNT_W)) begin : g_bad_on
      $error("multi_delay_timer: ON_DLY does not fit CNT_W");
   end
   if (64'(OFF_DLY) >= (64'd1 << CNT_W)) begin : g_bad_off
      $error("multi_delay_timer: OFF_DLY does not fit CNT_W");
   end

   logic [NCH-1:0] en_d1, en_d2, ds_d1, ds_d2;
   logic [NCH-1:0] en_rise, en_fall, dis_fall;
   logic [NCH-1:0] out_v, busy_v;

   // Synchronisers are not touched by CLR so edges arriving around a clear are kept.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         en_d1 <= '0;
         en_d2 <= '0;
         ds_d1 <= '0;
         ds_d2 <= '0;
      end else begin
         en_d1 <= bus.EN_IN;
         en_d2 <= en_d1;
         ds_d1 <= bus.DISABLE_IN;
         ds_d2 <= ds_d1;
      end
   end

   assign en_rise  =  en_d1 & ~en_d2;
   assign en_fall  = ~en_d1 &  en_d2;
   assign dis_fall = ~ds_d1 &  ds_d2;

`ifdef MDLY_CNT_RDBK_EN
   localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
   logic [NCH-1:0][CNT_W-1:0] cnt_all;
   logic [CNT_W-1:0]          rd_q;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      mdt_chan #(
        .CNT_W   (CNT_W),
        .ON_DLY  (ON_DLY),
        .OFF_DLY (OFF_DLY)
      ) u_ch (
        .SYSCLK   (SYSCLK),
        .RESET_N  (RESET_N),
        .clr      (bus.CLR),
        .en_rise  (en_rise[i]),
        .en_fall  (en_fall[i]),
        .dis_fall (dis_fall[i]),
        .out      (out_v[i]),
        .busy     (busy_v[i])
`ifdef MDLY_CNT_RDBK_EN
       ,.cnt_o    (cnt_all[i])
`endif
      );
   end

   assign bus.OUT  = out_v;
   assign bus.BUSY = busy_v;

`ifdef MDLY_CNT_RDBK_EN
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N)                         rd_q <= '0;
      else if (int'(bus.RD_SEL) < NCH)      rd_q <= cnt_all[bus.RD_SEL];
      else                                  rd_q <= '0;
   end
   assign bus.RD_CNT = rd_q;
`endif
endmodule

// File: tb/tb_multi_delay_timer.sv
// Bench for multi_delay_timer: two instances (delays 10/5 and 0/0) share stimulus and are
// compared each cycle against a deadline-based channel model plus explicit latency checks.
module tb_multi_delay_timer;
   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam int ON_A = 10, OFF_A = 5;

   logic SYSCLK, RESET_N;
   int   checks = 0, errors = 0;

   multi_delay_timer_if #(.NCH(NCH), .CNT_W(CW)) ifa ();
   multi_delay_timer_if #(.NCH(NCH), .CNT_W(CW)) ifb ();

   assign ifb.EN_IN      = ifa.EN_IN;
   assign ifb.DISABLE_IN = ifa.DISABLE_IN;
   assign ifb.CLR        = ifa.CLR;
`ifdef MDLY_CNT_RDBK_EN
   assign ifb.RD_SEL     = ifa.RD_SEL;
`endif

   multi_delay_timer #(.NCH(NCH), .CNT_W(CW), .ON_DLY(ON_A), .OFF_DLY(OFF_A))
     u_a (.SYSCLK(SYSCLK), .RESET_N(RESET_N), .bus(ifa));
   multi_delay_timer #(.NCH(NCH), .CNT_W(CW), .ON_DLY(0), .OFF_DLY(0))
     u_b (.SYSCLK(SYSCLK), .RESET_N(RESET_N), .bus(ifb));

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   // Model: phase 0 idle, 1 arming, 2 on, 3 releasing; dl = absolute edge of the next phase change.
   int             ph [2][NCH];
   longint         dl [2][NCH];
   longint         cyc = 0;
   logic [NCH-1:0] m_en1, m_en2, m_ds1, m_ds2;

   function automatic int on_of(int d);  return (d == 0) ? ON_A  : 0; endfunction
   function automatic int off_of(int d); return (d == 0) ? OFF_A : 0; endfunction

   function automatic logic [4*NCH-1:0] exp_all();
      logic [NCH-1:0] oa, ba, ob, bb;
      for (int c = 0; c < NCH; c++) begin
         oa[c] = (ph[0][c] == 2) || (ph[0][c] == 3);
         ba[c] = (ph[0][c] == 1) || (ph[0][c] == 3);
         ob[c] = (ph[1][c] == 2) || (ph[1][c] == 3);
         bb[c] = (ph[1][c] == 1) || (ph[1][c] == 3);
      end
      return {oa, ba, ob, bb};
   endfunction

   function automatic longint mcnt(int d, int c);
      return (ph[d][c] == 1 || ph[d][c] == 3) ? dl[d][c] - 1 - cyc : 0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < NCH; c++) begin
            ph[d][c] = 0;
            dl[d][c] = 0;
         end
      m_en1 = '0; m_en2 = '0; m_ds1 = '0; m_ds2 = '0;
   endtask

   task automatic tick();
      logic [NCH-1:0] er, ef, df;
      @(posedge SYSCLK);
      cyc++;
      if (!RESET_N) model_reset();
      else begin
         er = m_en1 & ~m_en2;
         ef = ~m_en1 & m_en2;
         df = ~m_ds1 & m_ds2;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
               if (ifa.CLR || ef[c]) ph[d][c] = 0;
               else case (ph[d][c])
                  0: if (er[c]) begin ph[d][c] = 1; dl[d][c] = cyc + on_of(d) + 1; end
                  1: if (df[c]) ph[d][c] = 0; else if (cyc == dl[d][c]) ph[d][c] = 2;
                  2: if (df[c]) begin ph[d][c] = 3; dl[d][c] = cyc + off_of(d) + 1; end
                  default: if (cyc == dl[d][c]) ph[d][c] = 0;
               endcase
            end
         m_en2 = m_en1; m_en1 = ifa.EN_IN;
         m_ds2 = m_ds1; m_ds1 = ifa.DISABLE_IN;
      end
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== '0) begin
         errors++; $display("FAIL reset_init got=%h exp=0", {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY});
      end
      ifa.EN_IN[0] = 1'b1;
      repeat (5) tick();
      checks++;
      if (ifa.BUSY[0] !== 1'b1) begin errors++; $display("FAIL reset_prearm got=%b exp=1", ifa.BUSY[0]); end
      RESET_N = 1'b0;
      ifa.EN_IN[0] = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== '0) begin
         errors++; $display("FAIL reset_async got=%h exp=0", {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY});
      end
      repeat (2) tick();
      RESET_N = 1'b1;
      repeat (15) begin
         tick();
         checks++;
         if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== exp_all()) begin
            errors++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY}, exp_all());
         end
      end
      checks++;
      if (ifa.BUSY[0] !== 1'b0 || ifa.OUT[0] !== 1'b0) begin
         errors++; $display("FAIL reset_stays_idle busy=%b out=%b exp=0", ifa.BUSY[0], ifa.OUT[0]);
      end
   endtask

   task automatic test_assert_delay();
      longint k;
      ifa.EN_IN[0] = 1'b1;
      k = cyc + 1;
      repeat (14) begin
         tick();
         checks++;
         if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== exp_all()) begin
            errors++; $display("FAIL assert_model cyc=%0d got=%h exp=%h", cyc, {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY}, exp_all());
         end
         if (cyc >= k + 1 && cyc <= k + 11) begin
            checks++;
            if (ifa.BUSY[0] !== 1'b1 || ifa.OUT[0] !== 1'b0) begin
               errors++; $display("FAIL assert_arming cyc=%0d busy=%b out=%b exp busy=1 out=0", cyc, ifa.BUSY[0], ifa.OUT[0]);
            end
         end
         if (cyc == k + 12) begin
            checks++;
            if (ifa.OUT[0] !== 1'b1 || ifa.BUSY[0] !== 1'b0) begin
               errors++; $display("FAIL assert_k12 out=%b busy=%b exp out=1 busy=0", ifa.OUT[0], ifa.BUSY[0]);
            end
         end
         if (cyc == k + 1 || cyc == k + 2) begin
            checks++;
            if (ifb.OUT[0] !== (cyc == k + 2)) begin
               errors++; $display("FAIL bound_on0 cyc=%0d got=%b exp=%b", cyc - k, ifb.OUT[0], cyc == k + 2);
            end
         end
      end
   endtask

   task automatic test_release_delay();
      longint k;
      ifa.EN_IN[1] = 1'b1;
      repeat (14) tick();
      checks++;
      if (ifa.OUT[1] !== 1'b1) begin errors++; $display("FAIL release_on got=%b exp=1", ifa.OUT[1]); end
      ifa.DISABLE_IN[1] = 1'b0;
      k = cyc + 1;
      repeat (8) begin
         tick();
         checks++;
         if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== exp_all()) begin
            errors++; $display("FAIL release_model cyc=%0d got=%h exp=%h", cyc, {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY}, exp_all());
         end
         if (cyc == k + 6 || cyc == k + 7) begin
            checks++;
            if (ifa.OUT[1] !== (cyc == k + 6)) begin
               errors++; $display("FAIL release_k7 at=k+%0d got=%b exp=%b", cyc - k, ifa.OUT[1], cyc == k + 6);
            end
         end
         if (cyc == k + 1 || cyc == k + 2) begin
            checks++;
            if (ifb.OUT[1] !== (cyc == k + 1)) begin
               errors++; $display("FAIL bound_off0 at=k+%0d got=%b exp=%b", cyc - k, ifb.OUT[1], cyc == k + 1);
            end
         end
      end
      ifa.DISABLE_IN[1] = 1'b1;
      ifa.EN_IN[1] = 1'b0;
      repeat (3) tick();
      ifa.EN_IN[1] = 1'b1;
      repeat (14) tick();
      ifa.DISABLE_IN[1] = 1'b0;
      repeat (3) tick();
      ifa.EN_IN[1] = 1'b0;
      k = cyc;
      repeat (3) begin
         tick();
         if (cyc == k + 1 || cyc == k + 2) begin
            checks++;
            if (ifa.OUT[1] !== (cyc == k + 1)) begin
               errors++; $display("FAIL release_enfall at=+%0d got=%b exp=%b", cyc - k, ifa.OUT[1], cyc == k + 1);
            end
         end
      end
      ifa.DISABLE_IN[1] = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_cancel();
      ifa.EN_IN[2] = 1'b1;
      repeat (14) tick();
      ifa.EN_IN[2] = 1'b0;
      ifa.DISABLE_IN[2] = 1'b0;
      repeat (2) tick();
      checks++;
      if (ifa.OUT[2] !== 1'b0 || ifa.BUSY[2] !== 1'b0 || ifb.OUT[2] !== 1'b0 || ifb.BUSY[2] !== 1'b0) begin
         errors++; $display("FAIL cancel_both out=%b%b busy=%b%b exp=0", ifa.OUT[2], ifb.OUT[2], ifa.BUSY[2], ifb.BUSY[2]);
      end
      ifa.DISABLE_IN[2] = 1'b1;
      repeat (3) tick();
      ifa.EN_IN[2] = 1'b1;
      repeat (4) tick();
      ifa.DISABLE_IN[2] = 1'b0;
      repeat (20) begin
         tick();
         checks++;
         if (ifa.OUT[2] !== 1'b0) begin errors++; $display("FAIL cancel_arm cyc=%0d got=%b exp=0", cyc, ifa.OUT[2]); end
         checks++;
         if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== exp_all()) begin
            errors++; $display("FAIL cancel_model cyc=%0d got=%h exp=%h", cyc, {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY}, exp_all());
         end
      end
      ifa.DISABLE_IN[2] = 1'b1;
      ifa.EN_IN[2] = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_clear();
      longint e;
      ifa.EN_IN = '0;
      repeat (3) tick();
      for (int c = 0; c < NCH; c++) begin
         ifa.EN_IN[c] = 1'b1;
         repeat (4) tick();
      end
      ifa.CLR = 1'b1;
      ifa.EN_IN[2] = 1'b0;
      tick();
      ifa.CLR = 1'b0;
      checks++;
      if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== '0) begin
         errors++; $display("FAIL clear_all got=%h exp=0", {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY});
      end
      repeat (3) tick();
      ifa.EN_IN[2] = 1'b1;
      e = cyc;
      repeat (15) begin
         tick();
         checks++;
         if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== exp_all()) begin
            errors++; $display("FAIL clear_model cyc=%0d got=%h exp=%h", cyc, {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY}, exp_all());
         end
         if (cyc == e + 2) begin
            checks++;
            if (ifa.BUSY !== 4'b0100 || ifa.OUT !== 4'b0000) begin
               errors++; $display("FAIL clear_rearm busy=%b out=%b exp busy=0100 out=0000", ifa.BUSY, ifa.OUT);
            end
         end
      end
   endtask

   task automatic test_boundary();
      longint k;
      ifa.EN_IN[3] = 1'b0;
      repeat (3) tick();
      ifa.EN_IN[3] = 1'b1;
      k = cyc + 1;
      repeat (3) begin
         tick();
         if (cyc == k + 1 || cyc == k + 2) begin
            checks++;
            if (ifb.OUT[3] !== (cyc == k + 2)) begin
               errors++; $display("FAIL bound_rise at=k+%0d got=%b exp=%b", cyc - k, ifb.OUT[3], cyc == k + 2);
            end
         end
      end
      ifa.DISABLE_IN[3] = 1'b0;
      k = cyc + 1;
      repeat (3) begin
         tick();
         if (cyc == k + 1 || cyc == k + 2) begin
            checks++;
            if (ifb.OUT[3] !== (cyc == k + 1)) begin
               errors++; $display("FAIL bound_fall at=k+%0d got=%b exp=%b", cyc - k, ifb.OUT[3], cyc == k + 1);
            end
         end
      end
      ifa.DISABLE_IN[3] = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_random();
      repeat (400) begin
         if ($urandom_range(7) == 0) ifa.EN_IN[$urandom_range(NCH-1)] ^= 1'b1;
         if ($urandom_range(7) == 0) ifa.DISABLE_IN[$urandom_range(NCH-1)] ^= 1'b1;
         ifa.CLR = ($urandom_range(49) == 0);
         tick();
         checks++;
         if ({ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY} !== exp_all()) begin
            errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, {ifa.OUT, ifa.BUSY, ifb.OUT, ifb.BUSY}, exp_all());
         end
      end
      ifa.CLR = 1'b0;
   endtask

`ifdef MDLY_CNT_RDBK_EN
   task automatic test_readback();
      longint prev;
      ifa.RD_SEL = 2'd2;
      ifa.EN_IN[2] = 1'b0;
      ifa.DISABLE_IN[2] = 1'b1;
      repeat (3) tick();
      ifa.EN_IN[2] = 1'b1;
      repeat (30) begin
         if (cyc % 20 == 0) ifa.DISABLE_IN[2] = ~ifa.DISABLE_IN[2];
         prev = mcnt(0, 2);
         tick();
         checks++;
         if (ifa.RD_CNT !== CW'(prev)) begin
            errors++; $display("FAIL readback_ch2 cyc=%0d got=%0d exp=%0d", cyc, ifa.RD_CNT, prev);
         end
      end
   endtask
`endif

   initial begin
      RESET_N = 1'b0;
      ifa.EN_IN = '0;
      ifa.DISABLE_IN = '1;
      ifa.CLR = 1'b0;
`ifdef MDLY_CNT_RDBK_EN
      ifa.RD_SEL = '0;
`endif
      model_reset();
      repeat (2) tick();
      RESET_N = 1'b1;
      test_reset();
      test_assert_delay();
      test_release_delay();
      test_cancel();
      test_clear();
      test_boundary();
      test_random();
`ifdef MDLY_CNT_RDBK_EN
      test_readback();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
